controlador_codificador: RTL
============================

Name: controlador_codificador

Overview:
- Shares one serial systematic cyclic encoder (LFSR, (N,K) code) between two message requesters.
- Round-robin arbitration with valid/ready handshakes on both inputs.
- Sequences K serial shift cycles, then presents the N-bit codeword with its requester ID on a valid/ready output.
- Sits between message sources and the channel/modulator stage of the coding datapath.

Parameters:
- N, 7, codeword length
- K, 4, message length
- G, 4'b1011, generator polynomial coefficients, width N-K+1, G[0] = x^0 term (x^3+x+1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- u0  in  K  requester 0 message
- valid0  in  1  requester 0 message valid
- ready0  out  1  requester 0 accept
- u1  in  K  requester 1 message
- valid1  in  1  requester 1 message valid
- ready1  out  1  requester 1 accept
- cw  out  N  codeword {parity[N-K-1:0], message[K-1:0]}
- cw_id  out  1  requester that owns cw
- cw_valid  out  1  cw/cw_id valid
- cw_ready  in  1  downstream accepts cw

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: state = IDLE; LFSR = 0; count = 0; cw = 0; cw_id = 0; cw_valid = 0; last_id = 1, so requester 0 wins the first tie.
- ready0/ready1: combinational. High only in IDLE, and only for the granted requester. At most one is high per cycle.
- Arbitration in IDLE:
  - Only one valid high: grant it.
  - Both high: grant ~last_id.
  - Acceptance = valid_x & ready_x.
- On acceptance: latch message into msg_reg, latch ID, set last_id = ID, clear LFSR, count = 0, go to SHIFT.
- SHIFT (K cycles): each cycle, bit b = msg_reg[count], feeding LSB first.
  - fb = b ^ LFSR[0]
  - LFSR[N-K-1] <= fb
  - LFSR[i] <= (fb & G[N-K-1-i]) ^ LFSR[i+1] for i = N-K-2 down to 0
  - count++
  - After count reaches K-1, go to OUT.
- OUT:
  - cw = {LFSR, msg_reg}, cw_valid = 1. Held stable while cw_ready = 0.
  - On cw_valid & cw_ready: cw_valid <= 0, go to IDLE.
  - cw/cw_id keep their last value after the handshake.
- Latency: acceptance at cycle t gives cw_valid first high at t+K+1.
- Throughput: minimum K+2 cycles per codeword. No acceptance in the same cycle as the output handshake.
- Input valid while busy: ignored, with ready low. Requester must hold valid/u stable until accepted.
- Inputs u0/u1 sampled only on acceptance; changes after acceptance have no effect.
- Reset mid-SHIFT or in OUT: codeword discarded, no cw_valid pulse, returns to reset values.
- An X on the non-granted u input must not propagate.

Optional Feature:
- Macro: CTRL_STATS_EN.
- Defined:
  - Adds output port cw_count (16 bits).
  - Increments on every cw_valid & cw_ready; wraps 16'hFFFF to 0; reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package codificador_pkg:
  - state enum {IDLE, SHIFT, OUT}
  - default N, K, G constants
  - localparam PW = N-K
- Sub-module lfsr_cyclic_enc:
  - Params N, K, G.
  - Inputs clk, rst, clr, en, bit_in; output parity [N-K-1:0].
  - Holds the LFSR update above.
- Controller owns the FSM, arbitration, msg_reg, count and output registers.

Test Plan:
- Single requester, u0 = 4'b0001, cw_ready = 1 -> cw = 7'b1010001, cw_id = 0, cw_valid high exactly at acceptance+5 for one cycle.
- u1 = 4'b0010 -> cw = 7'b1110010, cw_id = 1. Also u0 = 4'b1111 -> 7'b1111111; u0 = 4'b0000 -> 7'b0000000.
- Both valid continuously (u0 = 4'b0001, u1 = 4'b1111) -> grants alternate 0,1,0,1; cw sequence 1010001, 1111111, repeating; never two consecutive grants to the same ID.
- cw_ready held low 10 cycles in OUT -> cw/cw_id/cw_valid stable, ready0/ready1 low throughout; one handshake when released.
- rst asserted during SHIFT cycle 2 -> no cw_valid, all outputs 0 next cycle; the next request is then served by requester 0 first and encodes correctly.
- With CTRL_STATS_EN, 3 codewords handshaken -> cw_count = 3. Preload via 65535 handshakes -> cw_count wraps to 0.

Source files
------------

// File: rtl/codificador_pkg.sv
// Shared types and default code parameters for the serial cyclic encoder
// controller. Default code: (7,4) with generator x^3 + x + 1.
package codificador_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OUT
  } state_t;

  localparam int N_DEF = 7;
  localparam int K_DEF = 4;
  localparam int PW    = N_DEF - K_DEF;

  // Generator coefficients, bit 0 is the x^0 term
  localparam logic [PW:0] G_DEF = 4'b1011;

endpackage

// File: rtl/lfsr_cyclic_enc.sv
// Serial parity LFSR of a systematic cyclic (N,K) encoder. One message bit
// per enabled cycle; clr zeroes the register ahead of a new message.
module lfsr_cyclic_enc
  import codificador_pkg::*;
#(
  parameter int          N = N_DEF,
  parameter int          K = K_DEF,
  parameter logic [N-K:0] G = G_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic           bit_in,
  output logic [N-K-1:0] parity
);

  logic fb;

  // Feedback taps off the low end of the register
  always_comb fb = bit_in ^ parity[0];

  // Parity register: clear on request, otherwise shift with feedback
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      parity <= '0;
    end else if (en) begin
      parity[N-K-1] <= fb;
      for (int unsigned i = 0; i + 1 < N - K; i++) begin
        parity[i] <= (fb & G[N-K-1-i]) ^ parity[i+1];
      end
    end
  end

endmodule

// File: rtl/controlador_codificador.sv
// Two-requester round-robin front end for a shared serial cyclic encoder.
// Accepts one message, shifts it through the LFSR over K cycles, then holds
// the codeword on a valid/ready output until downstream takes it.
// Optional: define CTRL_STATS_EN to add the cw_count handshake counter port.
module controlador_codificador
  import codificador_pkg::*;
#(
  parameter int           N = N_DEF,
  parameter int           K = K_DEF,
  parameter logic [N-K:0] G = G_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] u0,
  input  logic         valid0,
  output logic         ready0,
  input  logic [K-1:0] u1,
  input  logic         valid1,
  output logic         ready1,
  output logic [N-1:0] cw,
  output logic         cw_id,
  output logic         cw_valid,
  input  logic         cw_ready
`ifdef CTRL_STATS_EN
  ,
  output logic [15:0]  cw_count
`endif
);

  localparam int CNTW = (K > 1) ? $clog2(K) : 1;

  state_t          state;
  logic [K-1:0]    msg_reg;
  logic [CNTW-1:0] count;
  logic            last_id;
  logic            idle;
  logic            grant;
  logic            accept;
  logic [K-1:0]    u_sel;
  logic [N-K-1:0]  parity;

  // Round-robin grant; only the granted, valid requester sees ready in IDLE
  always_comb begin
    idle   = (state == IDLE);
    grant  = (valid0 && valid1) ? ~last_id : valid1;
    ready0 = idle & valid0 & ~grant;
    ready1 = idle & valid1 & grant;
    accept = ready0 | ready1;
    u_sel  = grant ? u1 : u0;
  end

  lfsr_cyclic_enc #(
    .N(N),
    .K(K),
    .G(G)
  ) u_enc (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (state == SHIFT),
    .bit_in(msg_reg[count]),
    .parity(parity)
  );

  // The codeword is wired straight from the parity and message registers:
  // both are frozen from the last shift until the next acceptance, so cw
  // raises cw_valid in the same edge as the final shift and keeps its value
  // after the handshake without a separate output copy.
  assign cw = {parity, msg_reg};

  // Controller FSM: accept, shift K bits LSB first, present and hand off
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      msg_reg  <= '0;
      count    <= '0;
      cw_id    <= 1'b0;
      cw_valid <= 1'b0;
      last_id  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            msg_reg <= u_sel;
            cw_id   <= grant;
            last_id <= grant;
            count   <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          count <= count + 1'b1;
          if (count == CNTW'(K - 1)) begin
            count    <= '0;
            cw_valid <= 1'b1;
            state    <= OUT;
          end
        end
        OUT: begin
          if (cw_ready) begin
            cw_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CTRL_STATS_EN
  // Count completed output handshakes, wrapping naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      cw_count <= '0;
    end else if (cw_valid && cw_ready) begin
      cw_count <= cw_count + 16'd1;
    end
  end
`endif

endmodule
